// File: rtl/pipe_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl_pkg : shared encodings for the fetch sequencing control   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_ctrl_pkg;

   // Numeric order is the redirect priority, so merging is a plain compare.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MISP = 2'd1,
      SRC_ERET = 2'd2,
      SRC_EXC  = 2'd3
   } src_e;

   localparam logic [1:0] SELPC_NPC = 2'b00;
   localparam logic [1:0] SELPC_EPC = 2'b01;
   localparam logic [1:0] SELPC_EXC = 2'b10;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_REDIR = 2'd2
   } state_e;

   function automatic src_e src_max(input src_e a, input src_e b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_fetch_ctrl_if : hazard/redirect inputs, imem handshake, PC-mux  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pipe_fetch_ctrl_if;
   logic       stall;
   logic       exc_req;
   logic       eret;
   logic       pre_fch_wrong;
   logic       imem_ready;
   logic       imem_req;
   logic [1:0] selpc;
   logic       sel_refetch;
   logic       pc_we;
   logic       if_valid;
   logic       flush_if;
   logic       exc_ack;
   logic       ifetch_err;

   modport master (
      output stall, exc_req, eret, pre_fch_wrong, imem_ready,
      input  imem_req, selpc, sel_refetch, pc_we, if_valid, flush_if, exc_ack, ifetch_err
   );

   modport slave (
      input  stall, exc_req, eret, pre_fch_wrong, imem_ready,
      output imem_req, selpc, sel_refetch, pc_we, if_valid, flush_if, exc_ack, ifetch_err
   );
endinterface
`default_nettype wire

// File: rtl/pipe_fetch_ctrl_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | redirect_prio_latch : one-deep pending redirect source, priority-merged|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module redirect_prio_latch
   import fetch_ctrl_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic exc_req_i,
   input  wire logic eret_i,
   input  wire logic misp_i,
   input  wire logic take_i,
   output src_e      eff_src_o
);

   src_e pend_q;
   src_e pend_d;
   src_e evt;

   always_comb begin
      evt = SRC_NONE;
      if (exc_req_i)   evt = SRC_EXC;
      else if (eret_i) evt = SRC_ERET;
      else if (misp_i) evt = SRC_MISP;
   end

   assign eff_src_o = src_max(pend_q, evt);

   // Merging with the current pending value drops any lower-priority arrival.
   always_comb begin
      pend_d = eff_src_o;
      if (take_i) pend_d = SRC_NONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= SRC_NONE;
      else     pend_q <= pend_d;
   end

endmodule
`default_nettype wire

// File: rtl/pipe_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_fetch_ctrl : fetch PC-select sequencing, imem handshake, squash |
// | Optional FETCH_CTRL_PERF_EN adds misp_cnt / wait_cnt counters.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int BOOT_CYCLES = 2,
   parameter int TIMEOUT     = 16
)(
   input  wire logic        clk,
   input  wire logic        rst,
   pipe_fetch_ctrl_if.slave bus
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0]      misp_cnt,
   output logic [31:0]      wait_cnt
`endif
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [3:0] boot_q, boot_d;
   logic [7:0] tmo_q, tmo_d;
   src_e       eff_src;
   logic       take;
   logic       misp_taken;

   logic       imem_req, sel_refetch, pc_we, if_valid, flush_if, exc_ack, ifetch_err;
   logic [1:0] selpc;

   redirect_prio_latch u_prio (
      .clk       (clk),
      .rst       (rst),
      .exc_req_i (bus.exc_req),
      .eret_i    (bus.eret),
      .misp_i    (bus.pre_fch_wrong),
      .take_i    (take),
      .eff_src_o (eff_src)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
         boot_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      boot_d      = boot_q;
      tmo_d       = '0;
      take        = 1'b0;
      misp_taken  = 1'b0;
      imem_req    = 1'b0;
      selpc       = SELPC_NPC;
      sel_refetch = 1'b0;
      pc_we       = 1'b0;
      if_valid    = 1'b0;
      flush_if    = 1'b0;
      exc_ack     = 1'b0;
      ifetch_err  = 1'b0;

      case (state_q)
         ST_BOOT: begin
            boot_d = boot_q + 4'd1;
            if (boot_q == BOOT_LAST) begin
               state_d = ST_FETCH;
               boot_d  = '0;
            end
         end

         ST_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ready) begin
               if (eff_src != SRC_NONE) begin
                  // Redirect wins over stall; the returned word is squashed.
                  take     = 1'b1;
                  pc_we    = 1'b1;
                  flush_if = 1'b1;
                  state_d  = ST_REDIR;
                  case (eff_src)
                     SRC_EXC: begin
                        selpc   = SELPC_EXC;
                        exc_ack = 1'b1;
                     end
                     SRC_ERET: selpc = SELPC_EPC;
                     default: begin
                        sel_refetch = 1'b1;
                        misp_taken  = 1'b1;
                     end
                  endcase
               end else if (!bus.stall) begin
                  pc_we    = 1'b1;
                  if_valid = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               // Abandon the hung fetch and vector straight to the exception base.
               take       = 1'b1;
               ifetch_err = 1'b1;
               pc_we      = 1'b1;
               selpc      = SELPC_EXC;
               flush_if   = 1'b1;
               exc_ack    = 1'b1;
               state_d    = ST_REDIR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         ST_REDIR: begin
            flush_if = 1'b1;
            state_d  = ST_FETCH;
         end

         default: state_d = ST_BOOT;
      endcase
   end

   assign bus.imem_req    = imem_req;
   assign bus.selpc       = selpc;
   assign bus.sel_refetch = sel_refetch;
   assign bus.pc_we       = pc_we;
   assign bus.if_valid    = if_valid;
   assign bus.flush_if    = flush_if;
   assign bus.exc_ack     = exc_ack;
   assign bus.ifetch_err  = ifetch_err;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] misp_cnt_q, misp_cnt_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      misp_cnt_d = misp_cnt_q;
      wait_cnt_d = wait_cnt_q;
      if (misp_taken && (misp_cnt_q != 32'hFFFF_FFFF))
         misp_cnt_d = misp_cnt_q + 32'd1;
      if ((state_q == ST_FETCH) && !bus.imem_ready && (wait_cnt_q != 32'hFFFF_FFFF))
         wait_cnt_d = wait_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misp_cnt_q <= '0;
         wait_cnt_q <= '0;
      end else begin
         misp_cnt_q <= misp_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign misp_cnt = misp_cnt_q;
   assign wait_cnt = wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_fetch_ctrl : directed + random bench against a cycle model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_fetch_ctrl;

   localparam int BOOT_CYCLES = 2;
   localparam int TIMEOUT     = 16;
   localparam int M_BOOT  = 0;
   localparam int M_FETCH = 1;
   localparam int M_REDIR = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_fetch_ctrl_if bus ();

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] misp_cnt, wait_cnt;
`endif

   pipe_fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .misp_cnt (misp_cnt),
      .wait_cnt (wait_cnt)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;

   // got/exp layout: {imem_req, selpc[1:0], sel_refetch, pc_we, if_valid, flush_if, exc_ack, ifetch_err}
   logic [8:0]  got, exp;
   logic [31:0] got_m, got_w, exp_m, exp_w;

   // Reference model: mode, cycles spent in BOOT, pending source, consecutive wait cycles
   int          m_mode, m_boot, m_pend, m_waits;
   int          n_mode, n_pend, n_waits;
   logic [31:0] m_misp, m_wcnt, n_misp, n_wcnt;

   task automatic model_reset();
      m_mode = M_BOOT; m_boot = 0; m_pend = 0; m_waits = 0;
      m_misp = '0; m_wcnt = '0;
   endtask

   task automatic model_comb();
      int ev, src;
      ev  = bus.exc_req ? 3 : bus.eret ? 2 : bus.pre_fch_wrong ? 1 : 0;
      src = (m_pend > ev) ? m_pend : ev;
      exp = '0; n_mode = m_mode; n_pend = src; n_waits = 0;
      n_misp = m_misp; n_wcnt = m_wcnt;
      if (m_mode == M_BOOT) begin
         if (m_boot + 1 == BOOT_CYCLES) n_mode = M_FETCH;
      end else if (m_mode == M_REDIR) begin
         exp[2] = 1'b1; n_mode = M_FETCH;
      end else begin
         exp[8] = 1'b1;
         if (bus.imem_ready) begin
            if (src != 0) begin
               exp[4] = 1'b1; exp[2] = 1'b1; n_pend = 0; n_mode = M_REDIR;
               if (src == 3) begin exp[7:6] = 2'b10; exp[1] = 1'b1; end
               else if (src == 2) exp[7:6] = 2'b01;
               else begin
                  exp[5] = 1'b1;
                  if (n_misp != 32'hFFFF_FFFF) n_misp = n_misp + 1;
               end
            end else if (!bus.stall) begin
               exp[4] = 1'b1; exp[3] = 1'b1;
            end
         end else begin
            if (n_wcnt != 32'hFFFF_FFFF) n_wcnt = n_wcnt + 1;
            if (m_waits + 1 == TIMEOUT) begin
               exp = 9'b1_10_0_1_0_1_1_1; n_pend = 0; n_mode = M_REDIR;
            end else begin
               n_waits = m_waits + 1;
            end
         end
      end
   endtask

   // Called just after a negedge with inputs already driven; samples mid-low-phase.
   task automatic tick();
      #1;
      model_comb();
      got = {bus.imem_req, bus.selpc, bus.sel_refetch, bus.pc_we, bus.if_valid,
             bus.flush_if, bus.exc_ack, bus.ifetch_err};
      exp_m = m_misp; exp_w = m_wcnt;
`ifdef FETCH_CTRL_PERF_EN
      got_m = misp_cnt; got_w = wait_cnt;
`else
      got_m = exp_m; got_w = exp_w;
`endif
      @(posedge clk);
      m_boot  = m_boot + 1;
      m_mode  = n_mode; m_pend = n_pend; m_waits = n_waits;
      m_misp  = n_misp; m_wcnt = n_wcnt;
      @(negedge clk);
   endtask

   task automatic drive(input logic st, input logic ex, input logic er, input logic mp, input logic rd);
      bus.stall = st; bus.exc_req = ex; bus.eret = er; bus.pre_fch_wrong = mp; bus.imem_ready = rd;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      n_chk++;
      if ({bus.imem_req, bus.selpc, bus.sel_refetch, bus.pc_we, bus.if_valid,
           bus.flush_if, bus.exc_ack, bus.ifetch_err} !== 9'b0)
         $display("FAIL reset_outs got=%b exp=%b", {bus.imem_req, bus.selpc, bus.pc_we}, 4'b0);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_chk++;
         if (got[8] !== (i == 3)) $display("FAIL boot_req cyc%0d got=%b exp=%b", i, got[8], (i == 3));
         else n_pass++;
      end
   endtask

   task automatic test_sequential();
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++;
         if (got !== exp || got[4] !== 1'b1 || got[3] !== 1'b1)
            $display("FAIL seq_fetch cyc%0d got=%b exp=%b", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_misp_ready();
      drive(0, 0, 0, 1, 1);
      tick();
      n_chk++;
      if (got !== exp || got[5:4] !== 2'b11 || got[2] !== 1'b1 || got[3] !== 1'b0)
         $display("FAIL misp_ready got=%b exp=%b", got, exp);
      else n_pass++;
      drive(0, 0, 0, 0, 1);
      tick();
      n_chk++;
      if (got !== exp || got[8] !== 1'b0 || got[2] !== 1'b1)
         $display("FAIL misp_redir got=%b exp=%b", got, exp);
      else n_pass++;
      tick();
   endtask

   task automatic test_misp_wait();
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.pre_fch_wrong = 1'b0;
         n_chk++;
         if (got !== exp || got[4] !== 1'b0) $display("FAIL misp_wait t+%0d got=%b exp=%b", i, got, exp);
         else n_pass++;
      end
      bus.imem_ready = 1'b1;
      tick();
      n_chk++;
      if (got !== exp || got[5] !== 1'b1 || got[3] !== 1'b0 || got[4] !== 1'b1)
         $display("FAIL misp_late_apply got=%b exp=%b", got, exp);
      else n_pass++;
      tick();
   endtask

   task automatic test_exc_over_misp();
      drive(0, 0, 0, 1, 0);
      tick();
      drive(0, 1, 0, 0, 0);
      tick();
      bus.imem_ready = 1'b1;
      tick();
      n_chk++;
      if (got !== exp || got[7:6] !== 2'b10 || got[1] !== 1'b1 || got[5] !== 1'b0)
         $display("FAIL exc_over_misp got=%b exp=%b", got, exp);
      else n_pass++;
      bus.exc_req = 1'b0;
      tick();
      tick();
      n_chk++;
      if (got !== exp || got[4] !== 1'b1 || got[3] !== 1'b1 || got[5] !== 1'b0)
         $display("FAIL misp_dropped got=%b exp=%b", got, exp);
      else n_pass++;
   endtask

   task automatic test_stall_eret();
      drive(1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (got !== exp || got[4] !== 1'b0 || got[3] !== 1'b0)
            $display("FAIL stall_hold cyc%0d got=%b exp=%b", i, got, exp);
         else n_pass++;
      end
      bus.eret = 1'b1;
      tick();
      n_chk++;
      if (got !== exp || got[7:6] !== 2'b01 || got[4] !== 1'b1)
         $display("FAIL eret_in_stall got=%b exp=%b", got, exp);
      else n_pass++;
      drive(0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_timeout();
      drive(0, 0, 0, 0, 0);
      tick();
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (bus.imem_req !== 1'b0 || bus.pc_we !== 1'b0)
         $display("FAIL midfetch_reset got=%b exp=%b", {bus.imem_req, bus.pc_we}, 2'b00);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= BOOT_CYCLES + TIMEOUT; i++) begin
         tick();
         if (i > BOOT_CYCLES) begin
            n_chk++;
            if (got !== exp || got[0] !== (i == BOOT_CYCLES + TIMEOUT))
               $display("FAIL timeout fcyc%0d got=%b exp=%b", i - BOOT_CYCLES, got, exp);
            else n_pass++;
         end
      end
      n_chk++;
      if (got[7:6] !== 2'b10 || got[1] !== 1'b1 || got[2] !== 1'b1)
         $display("FAIL timeout_redirect got=%b exp=%b", got[7:0], 8'b10_0_1_0_1_1_1);
      else n_pass++;
      tick();
`ifdef FETCH_CTRL_PERF_EN
      n_chk++;
      if (got_w !== 32'd16) $display("FAIL wait_cnt got=%0d exp=%0d", got_w, 16);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      int drought = 0;
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 1500; i++) begin
         if (drought > 0) begin
            drought--;
            bus.imem_ready = 1'b0;
         end else begin
            if ($urandom_range(0, 99) < 2) drought = 20;
            bus.imem_ready = ($urandom_range(0, 99) < 55);
         end
         bus.stall         = ($urandom_range(0, 99) < 25);
         bus.eret          = ($urandom_range(0, 99) < 5);
         bus.pre_fch_wrong = ($urandom_range(0, 99) < 8);
         if (!bus.exc_req) bus.exc_req = ($urandom_range(0, 99) < 3);
         tick();
         if (exp[1]) bus.exc_req = 1'b0;
         n_chk++;
         if (got !== exp) $display("FAIL random cyc%0d got=%b exp=%b", i, got, exp);
         else n_pass++;
         n_chk++;
         if (got_m !== exp_m || got_w !== exp_w)
            $display("FAIL perf cyc%0d got=%0d/%0d exp=%0d/%0d", i, got_m, got_w, exp_m, exp_w);
         else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequential();
      test_misp_ready();
      test_misp_wait();
      test_exc_over_misp();
      test_stall_eret();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
